// File: rtl/framebuf_dither_ctrl.sv
// Frame-buffer RAM arbiter: strict-priority VGA reads, FIFO-buffered UART writes,
// fixed 3-cycle read latency, and frame-aligned dithering mode control.
module framebuf_dither_ctrl #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              vsync_pulse,
  input  logic              sw_dither,
  output logic              dither_en,
  output logic              frame_par,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2
  } gnt_e;

  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              r_rd_s1;
  logic              r_rd_s2;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_armed;
  gnt_e              w_gnt;
  logic              w_push;
  logic              w_pop;

  // One grant per cycle: reader always wins, otherwise drain the FIFO head.
  always_comb begin
    w_gnt = GNT_IDLE;
    if (rd_req) begin
      w_gnt = GNT_READ;
    end else if (r_count != '0) begin
      w_gnt = GNT_WRITE;
    end
  end

  // wr_ready is the registered not-full flag, so a pop never frees a slot early.
  assign w_push = wr_req && wr_ready;
  assign w_pop  = (w_gnt == GNT_WRITE);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      wr_ready <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count  <= w_count_nxt;
      wr_ready <= (w_count_nxt != CNT_FULL);
    end
  end

  // FIFO storage needs no reset; the count alone defines validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= wr_addr;
      r_fifo_data[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (w_gnt)
        GNT_READ: begin
          mem_en   <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= rd_addr;
        end
        GNT_WRITE: begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= r_fifo_addr[r_rptr];
          mem_wdata <= r_fifo_data[r_rptr];
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Read valid shift: command issued, RAM access, capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_s1  <= 1'b0;
      r_rd_s2  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      r_rd_s1  <= (w_gnt == GNT_READ);
      r_rd_s2  <= r_rd_s1;
      rd_valid <= r_rd_s2;
      if (r_rd_s2) rd_data <= mem_rdata;
    end
  end

  // r_armed masks a vsync landing on the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_armed   <= 1'b0;
      dither_en <= 1'b0;
      frame_par <= 1'b0;
    end else begin
      r_sync1 <= sw_dither;
      r_sync2 <= r_sync1;
      r_armed <= 1'b1;
      if (vsync_pulse && r_armed) begin
        dither_en <= r_sync2;
        frame_par <= ~frame_par;
      end
    end
  end

endmodule

// File: tb/tb_framebuf_dither_ctrl.sv
// Directed bench for framebuf_dither_ctrl: reset, read stream, priority/fill,
// push-pop overlap, dither latching and reset during an in-flight read.
module tb_framebuf_dither_ctrl;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 24;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              vsync_pulse = 1'b0;
  logic              sw_dither = 1'b0;
  logic              dither_en;
  logic              frame_par;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int wcount  = 0;

  framebuf_dither_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .vsync_pulse(vsync_pulse), .sw_dither(sw_dither),
    .dither_en(dither_en), .frame_par(frame_par),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous read returning addr*3
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= 24'(32'(mem_addr) * 32'd3);
    if (mem_en && mem_we) wcount = wcount + 1;
  end

  typedef struct {
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              e_valid;
    logic [DATA_W-1:0] e_data;
    logic              e_en;
    logic [ADDR_W-1:0] e_addr;
  } vec_t;

  vec_t vec [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_req      = 1'b0;
    wr_req      = 1'b0;
    vsync_pulse = 1'b0;
  endtask

  initial begin
    int j;
    int wc0;
    logic acc;

    // rd_req, rd_addr, e_valid, e_data, e_en, e_addr
    vec[0]  = '{1'b1, 15'd0, 1'b0, 24'd0,  1'b0, 15'd0};
    vec[1]  = '{1'b1, 15'd1, 1'b0, 24'd0,  1'b1, 15'd0};
    vec[2]  = '{1'b1, 15'd2, 1'b0, 24'd0,  1'b1, 15'd1};
    vec[3]  = '{1'b1, 15'd3, 1'b1, 24'd0,  1'b1, 15'd2};
    vec[4]  = '{1'b1, 15'd4, 1'b1, 24'd3,  1'b1, 15'd3};
    vec[5]  = '{1'b1, 15'd5, 1'b1, 24'd6,  1'b1, 15'd4};
    vec[6]  = '{1'b1, 15'd6, 1'b1, 24'd9,  1'b1, 15'd5};
    vec[7]  = '{1'b1, 15'd7, 1'b1, 24'd12, 1'b1, 15'd6};
    vec[8]  = '{1'b0, 15'd0, 1'b1, 24'd15, 1'b1, 15'd7};
    vec[9]  = '{1'b0, 15'd0, 1'b1, 24'd18, 1'b0, 15'd0};
    vec[10] = '{1'b0, 15'd0, 1'b1, 24'd21, 1'b0, 15'd0};
    vec[11] = '{1'b0, 15'd0, 1'b0, 24'd0,  1'b0, 15'd0};

    // Reset held with random inputs
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rd_req      = 1'($urandom);
      rd_addr     = ADDR_W'($urandom);
      wr_req      = 1'($urandom);
      wr_addr     = ADDR_W'($urandom);
      wr_data     = DATA_W'($urandom);
      vsync_pulse = 1'($urandom);
      sw_dither   = 1'($urandom);
      step();
    end
    chk("rst_rd_valid",  32'(rd_valid),  32'd0);
    chk("rst_rd_data",   32'(rd_data),   32'd0);
    chk("rst_mem_en",    32'(mem_en),    32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_wr_ready",  32'(wr_ready),  32'd1);
    chk("rst_dither_en", 32'(dither_en), 32'd0);
    chk("rst_frame_par", 32'(frame_par), 32'd0);
    idle_inputs();
    sw_dither = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_mem_en", 32'(mem_en), 32'd0);
    end

    // Back-to-back read stream from the vector table
    for (int i = 0; i < 12; i++) begin
      rd_req  = vec[i].rd_req;
      rd_addr = vec[i].rd_addr;
      chk($sformatf("rs%0d_rd_valid", i), 32'(rd_valid), 32'(vec[i].e_valid));
      if (vec[i].e_valid) chk($sformatf("rs%0d_rd_data", i), 32'(rd_data), 32'(vec[i].e_data));
      chk($sformatf("rs%0d_mem_en", i), 32'(mem_en), 32'(vec[i].e_en));
      chk($sformatf("rs%0d_mem_we", i), 32'(mem_we), 32'd0);
      if (vec[i].e_en) chk($sformatf("rs%0d_mem_addr", i), 32'(mem_addr), 32'(vec[i].e_addr));
      step();
    end
    idle_inputs();
    step();

    // Reader holds the RAM while six writes are offered
    wc0     = wcount;
    rd_req  = 1'b1;
    rd_addr = 15'd100;
    j = 0;
    for (int c = 0; c < 8; c++) begin
      wr_req  = (j < 6);
      wr_addr = ADDR_W'(200 + j);
      wr_data = 24'h100000 + 24'(j);
      acc = wr_req && wr_ready;
      step();
      if (acc) j++;
    end
    chk("fill_accepted", 32'(j), 32'd4);
    chk("fill_wr_ready", 32'(wr_ready), 32'd0);
    chk("fill_no_write", 32'(wcount - wc0), 32'd0);
    idle_inputs();
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_mem_we", k), 32'(mem_we), 32'd1);
      chk($sformatf("drain%0d_addr", k), 32'(mem_addr), 32'(200 + k));
      chk($sformatf("drain%0d_data", k), 32'(mem_wdata), 32'h100000 + 32'(k));
      if (k == 0) chk("drain_wr_ready", 32'(wr_ready), 32'd1);
      step();
    end
    chk("drain_done_mem_en", 32'(mem_en), 32'd0);
    chk("drain_done_wr_ready", 32'(wr_ready), 32'd1);

    // Simultaneous push and pop with two entries queued
    rd_req = 1'b1; rd_addr = '0;
    wr_req = 1'b1; wr_addr = 15'd300; wr_data = 24'hAA0000;
    step();
    wr_addr = 15'd301; wr_data = 24'h00BB00;
    step();
    rd_req = 1'b0;
    wr_addr = 15'd302; wr_data = 24'h0000CC;
    chk("pp_ready0", 32'(wr_ready), 32'd1);
    step();
    wr_addr = 15'd303; wr_data = 24'h123456;
    chk("pp_we0", 32'(mem_we), 32'd1);
    chk("pp_data0", 32'(mem_wdata), 32'hAA0000);
    chk("pp_ready1", 32'(wr_ready), 32'd1);
    step();
    wr_req = 1'b0;
    chk("pp_we1", 32'(mem_we), 32'd1);
    chk("pp_data1", 32'(mem_wdata), 32'h00BB00);
    chk("pp_addr1", 32'(mem_addr), 32'd301);
    chk("pp_ready2", 32'(wr_ready), 32'd1);
    step();
    chk("pp_we2", 32'(mem_we), 32'd1);
    chk("pp_data2", 32'(mem_wdata), 32'h0000CC);
    step();
    chk("pp_we3", 32'(mem_we), 32'd1);
    chk("pp_data3", 32'(mem_wdata), 32'h123456);
    step();
    chk("pp_idle", 32'(mem_we), 32'd0);

    // Dither switch latched only at vsync; frame_par toggles once per frame
    sw_dither = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("dith_hold", 32'(dither_en), 32'd0);
    end
    chk("par_before", 32'(frame_par), 32'd0);
    for (int f = 0; f < 3; f++) begin
      vsync_pulse = 1'b1;
      step();
      vsync_pulse = 1'b0;
      chk($sformatf("dith_f%0d", f), 32'(dither_en), 32'd1);
      chk($sformatf("par_f%0d", f), 32'(frame_par), 32'((f + 1) % 2));
      for (int c = 0; c < 4; c++) step();
      chk($sformatf("par_hold_f%0d", f), 32'(frame_par), 32'((f + 1) % 2));
    end

    // Reset one cycle after a read and a push; vsync coincides with release
    rd_req = 1'b1; rd_addr = 15'd7;
    wr_req = 1'b1; wr_addr = 15'd400; wr_data = 24'h777777;
    step();
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    wc0 = wcount;
    rst = 1'b1;
    vsync_pulse = 1'b1;
    step();
    vsync_pulse = 1'b0;
    chk("rel_frame_par", 32'(frame_par), 32'd0);
    chk("rel_dither_en", 32'(dither_en), 32'd0);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("rel_rd_valid%0d", c), 32'(rd_valid), 32'd0);
      step();
    end
    chk("rel_fifo_lost", 32'(wcount - wc0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/framebuf_dither_ctrl.md
# framebuf_dither_ctrl

Arbiter and sequencer in front of the single-port frame-buffer RAM of the VGA serial display. Shares the RAM between the VGA pixel reader, which has strict priority, and the UART pixel writer, which is buffered in a small write FIFO. Delivers read pixels with fixed latency to the dithering stage. Also owns the dithering mode: the raw switch is synchronised and applied only at frame boundaries, so a frame is never half-dithered.

## Interface
- ADDR_W, 15, frame-buffer word address width
- DATA_W, 24, pixel width ({B,G,R} 8 bits each)
- FIFO_DEPTH, 4, write FIFO entries (power of two, ≥2)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rd_req  in  1  reader wants pixel at rd_addr this cycle
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read pixel
- rd_valid  out  1  rd_data valid this cycle
- wr_req  in  1  writer presents wr_addr/wr_data
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write pixel
- wr_ready  out  1  FIFO not full; push occurs when wr_req && wr_ready
- vsync_pulse  in  1  one-cycle frame-start strobe
- sw_dither  in  1  raw, asynchronous dithering switch
- dither_en  out  1  frame-stable dithering enable, drives the dithering SW input
- frame_par  out  1  toggles every frame (temporal dithering phase)
- mem_en, mem_we  out  1 each  RAM strobe / write enable (registered)
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en && !mem_we

## Operation
- Each cycle, one grant:
  - READ if rd_req.
  - Else WRITE if FIFO non-empty (pops head).
  - Else IDLE.
- The grant registers mem_en/mem_we/mem_addr/mem_wdata. IDLE gives mem_en=0 and mem_we=0.
- Read pipeline is a 3-stage valid shift:
  - stage 1: mem command registered
  - stage 2: RAM access
  - stage 3: rd_data <= mem_rdata, rd_valid <= 1
- Back-to-back reads sustain one pixel per cycle.
- Write FIFO:
  - Circular buffer with log2(FIFO_DEPTH)+1-bit count.
  - wr_ready = (count != FIFO_DEPTH).
  - Push and pop in the same cycle leave count unchanged.
  - Push is blocked when full, even if a pop occurs that cycle; wr_ready is registered-state based only.
- No write starvation override. Continuous rd_req (visible region) holds the FIFO. The writer stalls on wr_ready=0 and drains during blanking.
- A read of an address still pending in the FIFO returns old RAM contents. This is allowed; no forwarding.
- Dither mode:
  - sw_dither passes through a 2-FF synchroniser.
  - On a cycle with vsync_pulse=1, dither_en <= synchronised value and frame_par toggles.
  - Otherwise both hold.

## Timing
- Reset values (asynchronous, on rst=0): rd_valid=0, rd_data=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, FIFO empty (wr_ready=1), dither_en=0, frame_par=0, synchroniser=0.
- Read latency: rd_req at cycle N gives rd_valid=1 in cycle N+3, with data from rd_addr sampled at N.
- Write latency:
  - Push at N into an empty FIFO with no rd_req at N+1 gives mem_we=1 in N+2.
  - The FIFO is registered; no same-cycle bypass.
- Reset mid-operation: in-flight reads are discarded (no rd_valid after release until a new rd_req), and FIFO contents are lost.
- sw_dither change to dither_en: at least 2 cycles of synchronisation, plus a wait to the next vsync_pulse.
- vsync_pulse coincident with reset release is ignored.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs at reset values, wr_ready=1. Release and drive 10 idle cycles → mem_en stays 0.
- Read stream: rd_req=1 for addresses 0..7 back-to-back, RAM model returns addr*3 → rd_valid high cycles 3..10, rd_data=0,3,…,21 in order.
- Priority and fill:
  - Hold rd_req=1 and push 6 writes.
  - 4 accepted, then wr_ready=0, no mem_we.
  - Drop rd_req → 4 writes issue on consecutive cycles in push order, then wr_ready=1.
- Simultaneous push/pop: FIFO at count 2, rd_req=0, wr_req=1 → count stays 2 and one mem write per cycle. Verify data order 0xAA0000, 0x00BB00, 0x0000CC.
- Dither latch: sw_dither 0→1 mid-frame → dither_en stays 0 until vsync_pulse, then 1 the next cycle. frame_par toggles exactly once per vsync_pulse over 3 frames.
- Reset mid-read: assert rst=0 one cycle after rd_req → no rd_valid is ever produced for that request.
